// File: rtl/uart_boot_loader_if.sv
// Memory write port driven by the UART boot loader: one-cycle write strobe,
// word-aligned byte address and write data.
interface uart_boot_loader_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (output mem_we, mem_addr, mem_wdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image over rx and writes it into memory,
// holding the CPU until the image is complete. Define UART_BOOT_CSUM_EN for the trailing XOR checksum.
module uart_boot_loader #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [15:0] MAX_WORDS = 16'd4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  uart_boot_loader_if.master         mem,
  output logic                       cpu_hold,
  output logic                       done,
  output logic                       err,
  output logic [15:0]                words
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int unsigned SYNC_STAGES  = 2;
  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;

  // ---------------------------------------------------------------- rx synchronizer
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;
  logic                   rx_prev_reg;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg[gi] <= 1'b1;
        end else if (gi == 0) begin
          sync_reg[gi] <= rx;
        end else begin
          sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign rx_s = sync_reg[SYNC_STAGES-1];

  // ---------------------------------------------------------------- byte receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             byte_vld_reg, byte_vld_next;
  logic             frame_err_reg, frame_err_next;
  logic             bit_end;

  assign bit_end = (cnt_reg == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg <= RX_IDLE;
    end else begin
      rx_state_reg <= rx_state_next;
    end
  end

  always_comb begin
    rx_state_next  = rx_state_reg;
    byte_vld_next  = 1'b0;
    frame_err_next = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (!rx_s && rx_prev_reg) rx_state_next = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_reg == HALF_LAST) rx_state_next = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (bit_end && bit_idx_reg == 3'd7) rx_state_next = RX_STOP;
      end
      RX_STOP: begin
        if (bit_end) begin
          rx_state_next  = RX_IDLE;
          byte_vld_next  = rx_s;
          frame_err_next = !rx_s;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_prev_reg   <= 1'b1;
      cnt_reg       <= '0;
      bit_idx_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      byte_vld_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      rx_prev_reg   <= rx_s;
      byte_vld_reg  <= byte_vld_next;
      frame_err_reg <= frame_err_next;
      case (rx_state_reg)
        RX_START: begin
          cnt_reg     <= (cnt_reg == HALF_LAST) ? '0 : cnt_reg + CNT_W'(1);
          bit_idx_reg <= 3'd0;
        end
        RX_DATA: begin
          if (bit_end) begin
            cnt_reg     <= '0;
            shift_reg   <= {rx_s, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RX_STOP: cnt_reg <= bit_end ? '0 : cnt_reg + CNT_W'(1);
        default: cnt_reg <= '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- frame FSM
  typedef enum logic [2:0] {
    F_IDLE,
    F_LEN_HI,
    F_LEN_LO,
    F_DATA,
`ifdef UART_BOOT_CSUM_EN
    F_CSUM,
`endif
    F_DONE,
    F_ERR
  } frame_state_t;

`ifdef UART_BOOT_CSUM_EN
  localparam frame_state_t AFTER_DATA = F_CSUM;
`else
  localparam frame_state_t AFTER_DATA = F_DONE;
`endif

  frame_state_t state_reg, state_next;
  logic [7:0]   len_hi_reg;
  logic [15:0]  length_reg;
  logic [15:0]  words_reg;
  logic [1:0]   byte_cnt_reg;
  logic [31:0]  word_reg;
  logic [31:0]  addr_reg;
  logic [31:0]  wdata_reg;
  logic         mem_we_reg;
  logic         cpu_hold_reg, done_reg, err_reg;
  logic [15:0]  len_rx;
  logic         start_frame, load_hi, load_lo, take_byte, issue_write;
`ifdef UART_BOOT_CSUM_EN
  logic [7:0]   csum_reg;
`endif

  assign len_rx = {len_hi_reg, shift_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= F_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    start_frame = 1'b0;
    load_hi     = 1'b0;
    load_lo     = 1'b0;
    take_byte   = 1'b0;
    issue_write = 1'b0;
    if (frame_err_reg) begin
      state_next = F_ERR;
    end else if (byte_vld_reg) begin
      case (state_reg)
        F_IDLE, F_DONE, F_ERR: begin
          if (shift_reg == SYNC_BYTE) begin
            start_frame = 1'b1;
            state_next  = F_LEN_HI;
          end
        end
        F_LEN_HI: begin
          load_hi    = 1'b1;
          state_next = F_LEN_LO;
        end
        F_LEN_LO: begin
          load_lo = 1'b1;
          if (len_rx > MAX_WORDS)  state_next = F_ERR;
          else if (len_rx == 16'd0) state_next = AFTER_DATA;
          else                      state_next = F_DATA;
        end
        F_DATA: begin
          take_byte = 1'b1;
          if (byte_cnt_reg == 2'd3) begin
            issue_write = 1'b1;
            if (words_reg == length_reg - 16'd1) state_next = AFTER_DATA;
          end
        end
`ifdef UART_BOOT_CSUM_EN
        F_CSUM: state_next = (shift_reg == csum_reg) ? F_DONE : F_ERR;
`endif
        default: state_next = F_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_reg   <= 8'h00;
      length_reg   <= 16'd0;
      words_reg    <= 16'd0;
      byte_cnt_reg <= 2'd0;
      word_reg     <= 32'h0;
      addr_reg     <= BASE_ADDR;
      wdata_reg    <= 32'h0;
      mem_we_reg   <= 1'b0;
      cpu_hold_reg <= 1'b1;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef UART_BOOT_CSUM_EN
      csum_reg     <= 8'h00;
`endif
    end else begin
      mem_we_reg   <= issue_write;
      cpu_hold_reg <= (state_reg != F_DONE);
      done_reg     <= (state_reg == F_DONE);
      err_reg      <= (state_reg == F_ERR);
      if (load_hi) len_hi_reg <= shift_reg;
      if (load_lo) length_reg <= len_rx;
      if (take_byte) begin
        word_reg     <= {word_reg[23:0], shift_reg};
        byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef UART_BOOT_CSUM_EN
        csum_reg     <= csum_reg ^ shift_reg;
`endif
      end
      // Address stays on the current word for the write cycle, then steps on.
      if (issue_write) begin
        wdata_reg <= {word_reg[23:0], shift_reg};
        words_reg <= words_reg + 16'd1;
      end
      if (mem_we_reg) addr_reg <= addr_reg + 32'd4;
      if (start_frame) begin
        words_reg    <= 16'd0;
        addr_reg     <= BASE_ADDR;
        byte_cnt_reg <= 2'd0;
`ifdef UART_BOOT_CSUM_EN
        csum_reg     <= 8'h00;
`endif
      end
    end
  end

  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;
  assign cpu_hold      = cpu_hold_reg;
  assign done          = done_reg;
  assign err           = err_reg;
  assign words         = words_reg;

endmodule
